// File: rtl/pipe_stage.sv
// Two-entry skid pipeline stage (head + skid) with flush and asynchronous reset.
// Optional forwarding outputs are built only when PIPE_STAGE_FWD_EN is defined.
module pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CTRL_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_busC,
   input  logic [DATA_W-1:0] i_out,
   input  logic [REG_W-1:0]  i_rd,
   input  logic [CTRL_W-1:0] i_signals,
   input  logic              i_flush,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_busC,
   output logic [DATA_W-1:0] o_out,
   output logic [REG_W-1:0]  o_rd,
   output logic [CTRL_W-1:0] o_signals,
   output logic              o_GPRWR,
   output logic              o_MTR,
   output logic [1:0]        o_count
`ifdef PIPE_STAGE_FWD_EN
   ,
   output logic              o_fwd_valid,
   output logic [REG_W-1:0]  o_fwd_rd,
   output logic [DATA_W-1:0] o_fwd_data
`endif
);

   logic              head_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_busC;
   logic [DATA_W-1:0] skid_out;
   logic [REG_W-1:0]  skid_rd;
   logic [CTRL_W-1:0] skid_signals;

   logic accept;
   logic consume;
   logic head_free;
   logic head_from_skid;
   logic head_from_in;
   logic skid_from_in;

   // skid_valid is itself a register, so o_ready is a registered value
   assign o_ready = ~skid_valid;
   assign accept  = i_valid & o_ready;
   assign consume = head_valid & i_ready;

   always_comb begin
      head_free      = ~head_valid | consume;
      head_from_skid = 1'b0;
      head_from_in   = 1'b0;
      skid_from_in   = 1'b0;
      if (!i_flush) begin
         if (head_free) begin
            head_from_skid = skid_valid;
            head_from_in   = ~skid_valid & accept;
            skid_from_in   = skid_valid & accept;
         end else begin
            skid_from_in   = accept;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
         o_busC     <= '0;
         o_out      <= '0;
         o_rd       <= '0;
         o_signals  <= '0;
      end else if (i_flush) begin
         head_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (head_free) begin
            head_valid <= skid_valid | accept;
            skid_valid <= skid_valid & accept;
         end else begin
            skid_valid <= skid_valid | accept;
         end
         if (head_from_skid) begin
            o_busC    <= skid_busC;
            o_out     <= skid_out;
            o_rd      <= skid_rd;
            o_signals <= skid_signals;
         end else if (head_from_in) begin
            o_busC    <= i_busC;
            o_out     <= i_out;
            o_rd      <= i_rd;
            o_signals <= i_signals;
         end
      end
   end

   // Skid payload contents are don't-care after reset, so no reset term here
   always_ff @(posedge clk) begin
      if (skid_from_in) begin
         skid_busC    <= i_busC;
         skid_out     <= i_out;
         skid_rd      <= i_rd;
         skid_signals <= i_signals;
      end
   end

   assign o_valid = head_valid;
   assign o_GPRWR = o_signals[CTRL_W-1] & head_valid;
   assign o_MTR   = o_signals[CTRL_W-2] & head_valid;
   assign o_count = {head_valid & skid_valid, head_valid ^ skid_valid};

`ifdef PIPE_STAGE_FWD_EN
   assign o_fwd_valid = o_GPRWR;
   assign o_fwd_rd    = o_rd;
   assign o_fwd_data  = o_MTR ? o_out : o_busC;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed testbench for pipe_stage: reset, latency, backpressure, skid, flush,
// asynchronous reset and (with PIPE_STAGE_FWD_EN) the forwarding outputs.
module tb_pipe_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_busC = '0;
   logic [31:0] i_out = '0;
   logic [4:0]  i_rd = '0;
   logic [1:0]  i_signals = '0;
   logic        i_flush = 1'b0;
   logic        i_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_busC;
   logic [31:0] o_out;
   logic [4:0]  o_rd;
   logic [1:0]  o_signals;
   logic        o_GPRWR;
   logic        o_MTR;
   logic [1:0]  o_count;
`ifdef PIPE_STAGE_FWD_EN
   logic        o_fwd_valid;
   logic [4:0]  o_fwd_rd;
   logic [31:0] o_fwd_data;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pipe_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(2)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_busC(i_busC), .i_out(i_out), .i_rd(i_rd), .i_signals(i_signals),
      .i_flush(i_flush), .i_ready(i_ready), .o_valid(o_valid),
      .o_busC(o_busC), .o_out(o_out), .o_rd(o_rd), .o_signals(o_signals),
      .o_GPRWR(o_GPRWR), .o_MTR(o_MTR), .o_count(o_count)
`ifdef PIPE_STAGE_FWD_EN
      , .o_fwd_valid(o_fwd_valid), .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] bc,
                        input logic [31:0] ou, input logic [1:0] sg);
      i_valid   = v;
      i_rd      = rd;
      i_busC    = bc;
      i_out     = ou;
      i_signals = sg;
   endtask

   initial begin
      // asynchronous reset, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_count", 32'(o_count), 32'h0);
      chk("rst_ready", 32'(o_ready), 32'h1);
      chk("rst_gprwr", 32'(o_GPRWR), 32'h0);
      chk("rst_mtr", 32'(o_MTR), 32'h0);
      chk("rst_busC", o_busC, 32'h0);
      chk("rst_rd", 32'(o_rd), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // single payload, 1-cycle latency
      drive(1'b1, 5'd3, 32'h11, 32'h22, 2'b10);
      i_ready = 1'b1;
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("single_valid", 32'(o_valid), 32'h1);
      chk("single_gprwr", 32'(o_GPRWR), 32'h1);
      chk("single_mtr", 32'(o_MTR), 32'h0);
      chk("single_rd", 32'(o_rd), 32'h3);
      chk("single_count", 32'(o_count), 32'h1);
      chk("single_busC", o_busC, 32'h11);
      chk("single_out", o_out, 32'h22);
      tick();
      chk("drain_valid", 32'(o_valid), 32'h0);
      chk("drain_count", 32'(o_count), 32'h0);
      chk("drain_gprwr", 32'(o_GPRWR), 32'h0);
      chk("drain_rd_hold", 32'(o_rd), 32'h3);

      // backpressure fills head then skid
      i_ready = 1'b0;
      drive(1'b1, 5'd1, 32'hA1, 32'hA2, 2'b01);
      tick();
      chk("bp_a_count", 32'(o_count), 32'h1);
      chk("bp_a_ready", 32'(o_ready), 32'h1);
      drive(1'b1, 5'd2, 32'hB1, 32'hB2, 2'b11);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("bp_full_count", 32'(o_count), 32'h2);
      chk("bp_full_ready", 32'(o_ready), 32'h0);
      chk("bp_full_rd", 32'(o_rd), 32'h1);
      chk("bp_full_mtr", 32'(o_MTR), 32'h1);
      chk("bp_full_gprwr", 32'(o_GPRWR), 32'h0);
      i_ready = 1'b1;
      tick();
      chk("bp_b_rd", 32'(o_rd), 32'h2);
      chk("bp_b_busC", o_busC, 32'hB1);
      chk("bp_b_count", 32'(o_count), 32'h1);
      chk("bp_b_ready", 32'(o_ready), 32'h1);
      chk("bp_b_gprwr", 32'(o_GPRWR), 32'h1);
      tick();
      chk("bp_empty_count", 32'(o_count), 32'h0);

      // full stage with C offered: C waits for the skid to drain, order A,B,C
      i_ready = 1'b0;
      drive(1'b1, 5'd1, 32'hA1, 32'hA2, 2'b10);
      tick();
      drive(1'b1, 5'd2, 32'hB1, 32'hB2, 2'b10);
      tick();
      chk("abc_full_count", 32'(o_count), 32'h2);
      chk("abc_head_a", 32'(o_rd), 32'h1);
      i_ready = 1'b1;
      drive(1'b1, 5'd4, 32'hC4, 32'hC5, 2'b10);
      tick();
      chk("abc_head_b", 32'(o_rd), 32'h2);
      chk("abc_b_count", 32'(o_count), 32'h1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("abc_head_c", 32'(o_rd), 32'h4);
      chk("abc_c_busC", o_busC, 32'hC4);
      chk("abc_c_count", 32'(o_count), 32'h1);
      tick();
      chk("abc_empty", 32'(o_count), 32'h0);

      // back-to-back stream with i_ready held high
      for (int unsigned k = 0; k < 3; k++) begin
         drive(1'b1, 5'(5 + k), 32'(16'h100 + k), 32'h0, 2'b10);
         tick();
         chk("stream_rd", 32'(o_rd), 32'(5 + k));
         chk("stream_count", 32'(o_count), 32'h1);
      end
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      tick();
      chk("stream_empty", 32'(o_valid), 32'h0);

      // flush with two held
      i_ready = 1'b0;
      drive(1'b1, 5'd8, 32'h8, 32'h8, 2'b10);
      tick();
      drive(1'b1, 5'd9, 32'h9, 32'h9, 2'b10);
      tick();
      chk("fl2_count_pre", 32'(o_count), 32'h2);
      drive(1'b1, 5'd10, 32'hA, 32'hA, 2'b10);
      i_flush = 1'b1;
      tick();
      chk("fl2_valid", 32'(o_valid), 32'h0);
      chk("fl2_count", 32'(o_count), 32'h0);
      chk("fl2_ready", 32'(o_ready), 32'h1);
      // flush while an input is actually accepted
      i_flush = 1'b0;
      drive(1'b1, 5'd11, 32'hB, 32'hB, 2'b10);
      tick();
      chk("fl1_count_pre", 32'(o_count), 32'h1);
      drive(1'b1, 5'd12, 32'hC, 32'hC, 2'b10);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("fl1_count", 32'(o_count), 32'h0);
      chk("fl1_gprwr", 32'(o_GPRWR), 32'h0);
      tick();
      chk("fl1_never", 32'(o_valid), 32'h0);
      chk("fl1_never_count", 32'(o_count), 32'h0);

      // reset between edges with two held
      drive(1'b1, 5'd20, 32'h20, 32'h20, 2'b10);
      tick();
      drive(1'b1, 5'd21, 32'h21, 32'h21, 2'b10);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("mr_count_pre", 32'(o_count), 32'h2);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", 32'(o_valid), 32'h0);
      chk("mr_count", 32'(o_count), 32'h0);
      chk("mr_ready", 32'(o_ready), 32'h1);
      chk("mr_busC", o_busC, 32'h0);
      chk("mr_gprwr", 32'(o_GPRWR), 32'h0);
      #2 rst = 1'b0;
      drive(1'b1, 5'd13, 32'h13, 32'h13, 2'b01);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("mr_after_count", 32'(o_count), 32'h1);
      chk("mr_after_rd", 32'(o_rd), 32'hd);

`ifdef PIPE_STAGE_FWD_EN
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      drive(1'b1, 5'd14, 32'h5, 32'h9, 2'b11);
      tick();
      chk("fwd_valid", 32'(o_fwd_valid), 32'h1);
      chk("fwd_rd", 32'(o_fwd_rd), 32'he);
      chk("fwd_data_mtr", o_fwd_data, 32'h9);
      i_ready = 1'b1;
      drive(1'b1, 5'd15, 32'h5, 32'h9, 2'b10);
      tick();
      drive(1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
      chk("fwd_data_alu", o_fwd_data, 32'h5);
      chk("fwd_rd2", 32'(o_fwd_rd), 32'hf);
      tick();
      chk("fwd_valid_off", 32'(o_fwd_valid), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
